// File: rtl/tap_upload_encoder.sv
// tap_upload_encoder
//   Serialises a RAM region as an Oric .TAP image and serves it to the host
//   through the ioctl upload port. It does the reverse of the cassette loader.
//   The image is the sync bytes, a 0x24 marker, a 9-byte header, the optional
//   name, a 0x00 terminator, and then the RAM body read through dpram port 2.
//   Every read has the same latency of RAM_LAT+1 cycles, whether it returns a
//   header byte, a body byte, or 0x00 for an index past the end of the image.
//
// Parameters
//   NSYNC    number of 0x16 sync bytes (1..15)
//   RAM_LAT  RAM read latency in clk_48 cycles (1..3)
//
// Configuration macro
//   TAP_UPLOAD_NAME_EN  adds the tape_name[127:0] input. The characters are
//                       MSB-first and the name ends at the first 0x00, up to
//                       16 characters. Without the macro the name field holds
//                       only the terminator.
//
// Ports
//   clk_48, reset              clock and synchronous active-high reset
//   start                      latch start_addr/end_addr/file_type/autorun
//                              (and tape_name) and arm
//   armed, size_err, file_size status of the latched image
//   done                       pulse on the edge that serves the last image byte
//   ioctl_upload/rd/addr       host read request
//   ioctl_din, ioctl_wait      host read response and hold-off
//   ram_addr, ram_rd, ram_q    RAM read port
//
// States
//   state   | meaning
//   S_IDLE  | no parameters latched; reads return 0x00
//   S_ARMED | image readable, waiting for a host read
//   S_FETCH | read accepted, counting down the RAM latency
//   S_RESP  | ram_q is valid; drive ioctl_din and release wait

module tap_upload_encoder #(
    parameter int NSYNC   = 4,
    parameter int RAM_LAT = 1
) (
    input  logic        clk_48,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] start_addr,
    input  logic [15:0] end_addr,
    input  logic        file_type,
    input  logic        autorun,
    output logic        armed,
    output logic        size_err,
    output logic [16:0] file_size,
    output logic        done,
    input  logic        ioctl_upload,
    input  logic        ioctl_rd,
    input  logic [24:0] ioctl_addr,
    output logic [7:0]  ioctl_din,
    output logic        ioctl_wait,
    output logic [15:0] ram_addr,
    output logic        ram_rd,
    input  logic [7:0]  ram_q
`ifdef TAP_UPLOAD_NAME_EN
    ,
    input  logic [127:0] tape_name
`endif
);

    // Sync bytes, the 0x24 marker, 9 header bytes and the name terminator.
    localparam int         HDR_FIXED = NSYNC + 11;
    localparam logic [1:0] LAT_INIT  = 2'(RAM_LAT - 1);

    typedef enum logic [1:0] {S_IDLE, S_ARMED, S_FETCH, S_RESP} state_t;

    state_t      state_q, state_d;
    logic        armed_q, armed_d;
    logic        size_err_q, size_err_d;
    logic [16:0] file_size_q, file_size_d;
    logic        done_q, done_d;
    logic [7:0]  din_q, din_d;
    logic        wait_q, wait_d;
    logic [15:0] ram_addr_q, ram_addr_d;
    logic        ram_rd_q, ram_rd_d;
    logic [15:0] start_q, start_d;
    logic [15:0] end_q, end_d;
    logic        type_q, type_d;
    logic        autorun_q, autorun_d;
    logic [4:0]  namelen_q, namelen_d;
    logic [1:0]  lat_q, lat_d;
    logic [7:0]  byte_q, byte_d;
    logic        body_q, body_d;
    logic        last_q, last_d;

    logic [4:0]  in_namelen;
    logic [16:0] in_body;
    logic [15:0] hdr_len;
    logic        in_image, is_body, is_last;
    logic [15:0] body_addr;
    logic [4:0]  hdr_k;
    logic [7:0]  hdr_byte;

`ifdef TAP_UPLOAD_NAME_EN
    logic [127:0] name_q, name_d;
    logic [127:0] name_sh;
    logic [3:0]   name_idx;
    logic         name_found;

    always_comb begin
        in_namelen = 5'd16;
        name_found = 1'b0;
        for (int c = 0; c < 16; c++) begin
            if (!name_found && tape_name[127-8*c -: 8] == 8'h00) begin
                in_namelen = 5'(c);
                name_found = 1'b1;
            end
        end
    end
`else
    assign in_namelen = 5'd0;
`endif

    // The body length is computed in 17 bits so that a full 64 KiB region fits.
    assign in_body = (end_addr >= start_addr) ?
                     (17'(end_addr) - 17'(start_addr) + 17'd1) : 17'd0;

    assign hdr_len  = 16'(HDR_FIXED) + 16'(namelen_q);
    assign in_image = ioctl_addr < {8'd0, file_size_q};
    assign is_body  = in_image && (ioctl_addr >= {9'd0, hdr_len});
    assign is_last  = ioctl_addr == {8'd0, file_size_q - 17'd1};
    // Only the low 16 bits matter because the body address wraps at 64 KiB.
    assign body_addr = start_q + (ioctl_addr[15:0] - hdr_len);
    // Header indices are below 43, so the low byte of the index is enough.
    assign hdr_k    = 5'(ioctl_addr[7:0] - 8'(NSYNC + 1));

    always_comb begin
        hdr_byte = 8'h00;
`ifdef TAP_UPLOAD_NAME_EN
        name_idx = 4'(hdr_k - 5'd9);
        name_sh  = name_q << (8 * name_idx);
`endif
        if (ioctl_addr < 25'(NSYNC)) begin
            hdr_byte = 8'h16;
        end else if (ioctl_addr == 25'(NSYNC)) begin
            hdr_byte = 8'h24;
        end else begin
            case (hdr_k)
                5'd2:    hdr_byte = type_q    ? 8'h80 : 8'h00;
                5'd3:    hdr_byte = autorun_q ? 8'h80 : 8'h00;
                5'd4:    hdr_byte = end_q[15:8];
                5'd5:    hdr_byte = end_q[7:0];
                5'd6:    hdr_byte = start_q[15:8];
                5'd7:    hdr_byte = start_q[7:0];
                default: hdr_byte = 8'h00;
            endcase
`ifdef TAP_UPLOAD_NAME_EN
            if (hdr_k >= 5'd9 && hdr_k < 5'd9 + namelen_q) begin
                hdr_byte = name_sh[127:120];
            end
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        armed_d     = armed_q;
        size_err_d  = size_err_q;
        file_size_d = file_size_q;
        done_d      = 1'b0;
        din_d       = din_q;
        wait_d      = wait_q;
        ram_addr_d  = ram_addr_q;
        ram_rd_d    = 1'b0;
        start_d     = start_q;
        end_d       = end_q;
        type_d      = type_q;
        autorun_d   = autorun_q;
        namelen_d   = namelen_q;
        lat_d       = lat_q;
        byte_d      = byte_q;
        body_d      = body_q;
        last_d      = last_q;
`ifdef TAP_UPLOAD_NAME_EN
        name_d      = name_q;
`endif

        if (start) begin
            // start takes priority over everything, including a read in flight.
            start_d     = start_addr;
            end_d       = end_addr;
            type_d      = file_type;
            autorun_d   = autorun;
            namelen_d   = in_namelen;
            size_err_d  = end_addr < start_addr;
            file_size_d = 17'(HDR_FIXED) + 17'(in_namelen) + in_body;
            armed_d     = 1'b1;
            wait_d      = 1'b0;
            state_d     = S_ARMED;
`ifdef TAP_UPLOAD_NAME_EN
            name_d      = tape_name;
`endif
        end else begin
            case (state_q)
                S_IDLE, S_ARMED: begin
                    if (ioctl_upload && ioctl_rd) begin
                        wait_d  = 1'b1;
                        lat_d   = LAT_INIT;
                        state_d = S_FETCH;
                        body_d  = armed_q && is_body;
                        last_d  = armed_q && is_last;
                        byte_d  = (armed_q && in_image && !is_body) ? hdr_byte : 8'h00;
                        if (armed_q && is_body) begin
                            ram_addr_d = body_addr;
                            ram_rd_d   = 1'b1;
                        end
                    end
                end
                S_FETCH: begin
                    if (!ioctl_upload) begin
                        wait_d  = 1'b0;
                        state_d = armed_q ? S_ARMED : S_IDLE;
                    end else if (lat_q == 2'd0) begin
                        state_d = S_RESP;
                    end else begin
                        lat_d = lat_q - 2'd1;
                    end
                end
                S_RESP: begin
                    wait_d  = 1'b0;
                    state_d = armed_q ? S_ARMED : S_IDLE;
                    if (ioctl_upload) begin
                        din_d  = body_q ? ram_q : byte_q;
                        done_d = last_q;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_48) begin
        if (reset) begin
            state_q     <= S_IDLE;
            armed_q     <= 1'b0;
            size_err_q  <= 1'b0;
            file_size_q <= 17'd0;
            done_q      <= 1'b0;
            din_q       <= 8'h00;
            wait_q      <= 1'b0;
            ram_addr_q  <= 16'd0;
            ram_rd_q    <= 1'b0;
            start_q     <= 16'd0;
            end_q       <= 16'd0;
            type_q      <= 1'b0;
            autorun_q   <= 1'b0;
            namelen_q   <= 5'd0;
            lat_q       <= 2'd0;
            byte_q      <= 8'h00;
            body_q      <= 1'b0;
            last_q      <= 1'b0;
`ifdef TAP_UPLOAD_NAME_EN
            name_q      <= 128'd0;
`endif
        end else begin
            state_q     <= state_d;
            armed_q     <= armed_d;
            size_err_q  <= size_err_d;
            file_size_q <= file_size_d;
            done_q      <= done_d;
            din_q       <= din_d;
            wait_q      <= wait_d;
            ram_addr_q  <= ram_addr_d;
            ram_rd_q    <= ram_rd_d;
            start_q     <= start_d;
            end_q       <= end_d;
            type_q      <= type_d;
            autorun_q   <= autorun_d;
            namelen_q   <= namelen_d;
            lat_q       <= lat_d;
            byte_q      <= byte_d;
            body_q      <= body_d;
            last_q      <= last_d;
`ifdef TAP_UPLOAD_NAME_EN
            name_q      <= name_d;
`endif
        end
    end

    assign armed      = armed_q;
    assign size_err   = size_err_q;
    assign file_size  = file_size_q;
    assign done       = done_q;
    assign ioctl_din  = din_q;
    assign ioctl_wait = wait_q;
    assign ram_addr   = ram_addr_q;
    assign ram_rd     = ram_rd_q;

endmodule

// File: tb/tb_tap_upload_encoder.sv
module tb_tap_upload_encoder;

    localparam int NSYNC   = 4;
    localparam int RAM_LAT = 1;

    logic        clk_48 = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [15:0] start_addr = '0;
    logic [15:0] end_addr = '0;
    logic        file_type = 1'b0;
    logic        autorun = 1'b0;
    logic        armed, size_err, done, ioctl_wait, ram_rd;
    logic [16:0] file_size;
    logic        ioctl_upload = 1'b1;
    logic        ioctl_rd = 1'b0;
    logic [24:0] ioctl_addr = '0;
    logic [7:0]  ioctl_din;
    logic [15:0] ram_addr;
    logic [7:0]  ram_q = 8'h00;
`ifdef TAP_UPLOAD_NAME_EN
    logic [127:0] tape_name = '0;
`endif

    always #5 clk_48 = ~clk_48;

    tap_upload_encoder #(.NSYNC(NSYNC), .RAM_LAT(RAM_LAT)) dut (
        .clk_48(clk_48), .reset(reset), .start(start),
        .start_addr(start_addr), .end_addr(end_addr),
        .file_type(file_type), .autorun(autorun),
        .armed(armed), .size_err(size_err), .file_size(file_size), .done(done),
        .ioctl_upload(ioctl_upload), .ioctl_rd(ioctl_rd), .ioctl_addr(ioctl_addr),
        .ioctl_din(ioctl_din), .ioctl_wait(ioctl_wait),
        .ram_addr(ram_addr), .ram_rd(ram_rd), .ram_q(ram_q)
`ifdef TAP_UPLOAD_NAME_EN
        , .tape_name(tape_name)
`endif
    );

    // Synchronous RAM with one cycle of read latency (RAM_LAT = 1).
    logic [7:0] mem [0:65535];
    always @(posedge clk_48) if (ram_rd) ram_q <= mem[ram_addr];

    int n_checks = 0;
    int n_fail   = 0;

    // Reference image, built from the layout rules as a byte list.
    logic [7:0] img[$];
    int         exp_size;
    int         exp_hdr;
    bit         exp_err;

    task automatic build_model(input logic [15:0] sa, input logic [15:0] ea,
                               input bit ft, input bit ar, input logic [127:0] nm);
        img.delete();
        repeat (NSYNC) img.push_back(8'h16);
        img.push_back(8'h24);
        img.push_back(8'h00); img.push_back(8'h00);
        img.push_back(ft ? 8'h80 : 8'h00);
        img.push_back(ar ? 8'h80 : 8'h00);
        img.push_back(ea[15:8]); img.push_back(ea[7:0]);
        img.push_back(sa[15:8]); img.push_back(sa[7:0]);
        img.push_back(8'h00);
`ifdef TAP_UPLOAD_NAME_EN
        for (int k = 0; k < 16; k++) begin
            if (nm[127-8*k -: 8] == 8'h00) break;
            img.push_back(nm[127-8*k -: 8]);
        end
`else
        if (nm != 128'd0) $display("note: name ignored in this build");
`endif
        img.push_back(8'h00);
        exp_hdr = img.size();
        exp_err = ea < sa;
        if (!exp_err)
            for (int a = int'(sa); a <= int'(ea); a++) img.push_back(mem[a]);
        exp_size = img.size();
    endtask

    task automatic do_start(input logic [15:0] sa, input logic [15:0] ea,
                            input bit ft, input bit ar);
        @(negedge clk_48);
        start_addr = sa; end_addr = ea; file_type = ft; autorun = ar; start = 1'b1;
        @(negedge clk_48);
        start = 1'b0;
    endtask

    // One host read: reports data, wait length, RAM strobes, last RAM address, done.
    task automatic read_byte(input int idx, output logic [7:0] d, output int wcyc,
                             output int nrd, output logic [15:0] raddr, output bit dn);
        @(negedge clk_48);
        ioctl_addr = 25'(idx); ioctl_rd = 1'b1;
        @(negedge clk_48);
        ioctl_rd = 1'b0;
        wcyc = 0; nrd = 0; dn = 0; raddr = 16'h0000;
        while (ioctl_wait && wcyc < 20) begin
            wcyc++;
            if (ram_rd) begin nrd++; raddr = ram_addr; end
            if (done) dn = 1;
            @(negedge clk_48);
        end
        if (ram_rd) begin nrd++; raddr = ram_addr; end
        if (done) dn = 1;
        d = ioctl_din;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk_48);
        n_checks++;
        if (armed !== 1'b0 || size_err !== 1'b0 || done !== 1'b0) begin
            n_fail++; $display("FAIL reset_flags armed=%b size_err=%b done=%b required 0 0 0", armed, size_err, done);
        end
        n_checks++;
        if (ioctl_wait !== 1'b0 || ioctl_din !== 8'h00 || file_size !== 17'd0) begin
            n_fail++; $display("FAIL reset_io wait=%b din=%h file_size=%0d required 0 00 0", ioctl_wait, ioctl_din, file_size);
        end
        n_checks++;
        if (ram_rd !== 1'b0 || ram_addr !== 16'h0000) begin
            n_fail++; $display("FAIL reset_ram ram_rd=%b ram_addr=%h required 0 0000", ram_rd, ram_addr);
        end
        reset = 1'b0;
    endtask

    task automatic test_unarmed();
        logic [7:0] d; int w, n; logic [15:0] ra; bit dn;
        read_byte(0, d, w, n, ra, dn);
        n_checks++;
        if (d !== 8'h00 || w != RAM_LAT + 1 || n != 0 || dn) begin
            n_fail++; $display("FAIL unarmed_read din=%h wait=%0d rd=%0d done=%b required 00 %0d 0 0", d, w, n, dn, RAM_LAT + 1);
        end
    endtask

    task automatic test_basic_image();
        logic [7:0] d; int w, n; logic [15:0] ra; bit dn;
        mem[16'h0501] = 8'h3C; mem[16'h0502] = 8'hC3; mem[16'h0503] = 8'h5A;
        build_model(16'h0501, 16'h0503, 1'b0, 1'b1, 128'd0);
        do_start(16'h0501, 16'h0503, 1'b0, 1'b1);
        n_checks++;
        if (file_size !== 17'd18 || armed !== 1'b1 || size_err !== 1'b0) begin
            n_fail++; $display("FAIL basic_size file_size=%0d armed=%b size_err=%b required 18 1 0", file_size, armed, size_err);
        end
        for (int i = 0; i < 18; i++) begin
            read_byte(i, d, w, n, ra, dn);
            n_checks++;
            if (d !== img[i] || w != RAM_LAT + 1 || dn != (i == 17) || n != ((i >= 15) ? 1 : 0)) begin
                n_fail++; $display("FAIL basic_byte[%0d] din=%h wait=%0d rd=%0d done=%b required %h %0d %0d %b",
                                   i, d, w, n, dn, img[i], RAM_LAT + 1, (i >= 15) ? 1 : 0, i == 17);
            end
            if (i >= 15) begin
                n_checks++;
                if (ra !== 16'(16'h0501 + i - 15)) begin
                    n_fail++; $display("FAIL basic_addr[%0d] ram_addr=%h required %h", i, ra, 16'(16'h0501 + i - 15));
                end
            end
        end
        foreach (img[i]) if (i < 0) $display("unused");
        read_byte(18, d, w, n, ra, dn);
        n_checks++;
        if (d !== 8'h00 || n != 0 || dn || w != RAM_LAT + 1) begin
            n_fail++; $display("FAIL past_end din=%h rd=%0d done=%b wait=%0d required 00 0 0 %0d", d, n, dn, w, RAM_LAT + 1);
        end
    endtask

    task automatic test_size_err();
        logic [7:0] d; int w, n; logic [15:0] ra; bit dn;
        do_start(16'h0500, 16'h0400, 1'b1, 1'b0);
        n_checks++;
        if (size_err !== 1'b1 || file_size !== 17'd15) begin
            n_fail++; $display("FAIL size_err flag=%b file_size=%0d required 1 15", size_err, file_size);
        end
        read_byte(15, d, w, n, ra, dn);
        n_checks++;
        if (d !== 8'h00 || n != 0) begin
            n_fail++; $display("FAIL size_err_read din=%h rd=%0d required 00 0", d, n);
        end
        read_byte(NSYNC + 5, d, w, n, ra, dn);
        n_checks++;
        if (d !== 8'h04) begin
            n_fail++; $display("FAIL size_err_end_hi din=%h required 04", d);
        end
    endtask

    task automatic test_wrap_reset();
        bit ok = 1;
        mem[16'hFFFF] = 8'hA5;
        do_start(16'hFFFF, 16'hFFFF, 1'b1, 1'b1);
        n_checks++;
        if (file_size !== 17'd16) begin
            n_fail++; $display("FAIL wrap_size file_size=%0d required 16", file_size);
        end
        @(negedge clk_48);
        ioctl_addr = 25'd15; ioctl_rd = 1'b1;
        @(negedge clk_48);
        ioctl_rd = 1'b0;
        n_checks++;
        if (ram_rd !== 1'b1 || ram_addr !== 16'hFFFF || ioctl_wait !== 1'b1) begin
            n_fail++; $display("FAIL wrap_fetch ram_rd=%b ram_addr=%h wait=%b required 1 ffff 1", ram_rd, ram_addr, ioctl_wait);
        end
        reset = 1'b1;
        @(negedge clk_48);
        n_checks++;
        if (ioctl_wait !== 1'b0 || armed !== 1'b0) begin
            n_fail++; $display("FAIL reset_abort wait=%b armed=%b required 0 0", ioctl_wait, armed);
        end
        reset = 1'b0;
        repeat (4) begin
            @(negedge clk_48);
            if (ioctl_din !== 8'h00 || ioctl_wait !== 1'b0 || done !== 1'b0) ok = 0;
        end
        n_checks++;
        if (!ok) begin
            n_fail++; $display("FAIL reset_late din=%h wait=%b done=%b required 00 0 0", ioctl_din, ioctl_wait, done);
        end
    endtask

    task automatic test_upload_abort();
        logic [7:0] d; int w, n; logic [15:0] ra; bit dn; bit ok = 1;
        build_model(16'h0501, 16'h0503, 1'b0, 1'b1, 128'd0);
        do_start(16'h0501, 16'h0503, 1'b0, 1'b1);
        read_byte(2, d, w, n, ra, dn);
        @(negedge clk_48);
        ioctl_addr = 25'd16; ioctl_rd = 1'b1;
        @(negedge clk_48);
        ioctl_rd = 1'b0; ioctl_upload = 1'b0;
        @(negedge clk_48);
        n_checks++;
        if (ioctl_wait !== 1'b0 || armed !== 1'b1 || file_size !== 17'd18) begin
            n_fail++; $display("FAIL upload_abort wait=%b armed=%b file_size=%0d required 0 1 18", ioctl_wait, armed, file_size);
        end
        // A read strobe while the upload window is closed must be ignored.
        ioctl_rd = 1'b1;
        @(negedge clk_48);
        ioctl_rd = 1'b0;
        repeat (3) begin
            @(negedge clk_48);
            if (ioctl_din !== 8'h16 || ioctl_wait !== 1'b0 || done !== 1'b0) ok = 0;
        end
        n_checks++;
        if (!ok) begin
            n_fail++; $display("FAIL upload_low din=%h wait=%b done=%b required 16 0 0", ioctl_din, ioctl_wait, done);
        end
        ioctl_upload = 1'b1;
        read_byte(16, d, w, n, ra, dn);
        n_checks++;
        if (d !== img[16] || n != 1) begin
            n_fail++; $display("FAIL upload_resume din=%h rd=%0d required %h 1", d, n, img[16]);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] d; int w, n; logic [15:0] ra; bit dn; int waits = 0;
        // A second strobe during wait is ignored; the first index is served.
        @(negedge clk_48);
        ioctl_addr = 25'd15; ioctl_rd = 1'b1;
        @(negedge clk_48);
        ioctl_addr = 25'd5;
        @(negedge clk_48);
        ioctl_rd = 1'b0;
        while (ioctl_wait && waits < 20) begin waits++; @(negedge clk_48); end
        n_checks++;
        if (ioctl_din !== img[15] || waits > 1) begin
            n_fail++; $display("FAIL rd_during_wait din=%h extra_wait=%0d required %h <=1", ioctl_din, waits, img[15]);
        end
        // start during a read aborts it and re-latches.
        for (int a = 16'h1000; a < 16'h1010; a++) mem[a] = 8'($urandom);
        @(negedge clk_48);
        ioctl_addr = 25'd16; ioctl_rd = 1'b1;
        @(negedge clk_48);
        ioctl_rd = 1'b0;
        start_addr = 16'h1000; end_addr = 16'h100F; file_type = 1'b1; autorun = 1'b0; start = 1'b1;
        @(negedge clk_48);
        start = 1'b0;
        n_checks++;
        if (ioctl_wait !== 1'b0 || file_size !== 17'd31 || ioctl_din !== img[15]) begin
            n_fail++; $display("FAIL start_abort wait=%b file_size=%0d din=%h required 0 31 %h", ioctl_wait, file_size, ioctl_din, img[15]);
        end
        build_model(16'h1000, 16'h100F, 1'b1, 1'b0, 128'd0);
        read_byte(15, d, w, n, ra, dn);
        n_checks++;
        if (d !== img[15] || ra !== 16'h1000) begin
            n_fail++; $display("FAIL start_relatch din=%h addr=%h required %h 1000", d, ra, img[15]);
        end
    endtask

    task automatic test_random();
        logic [7:0] d; int w, n; logic [15:0] ra; bit dn;
        logic [15:0] sa, ea; bit ft, ar; int idx; logic [7:0] ex;
        for (int it = 0; it < 12; it++) begin
            sa = 16'($urandom_range(16'h0100, 16'hFFFF));
            if (it % 4 == 3) ea = sa - 16'($urandom_range(1, 255));
            else             ea = sa + 16'($urandom_range(0, 30));
            ft = 1'($urandom); ar = 1'($urandom);
            for (int a = 0; a < 32; a++) mem[16'(sa + a)] = 8'($urandom);
            build_model(sa, ea, ft, ar, 128'd0);
            do_start(sa, ea, ft, ar);
            n_checks++;
            if (file_size !== 17'(exp_size) || size_err !== exp_err) begin
                n_fail++; $display("FAIL rand_size[%0d] file_size=%0d size_err=%b required %0d %b", it, file_size, size_err, exp_size, exp_err);
            end
            for (int r = 0; r < 6; r++) begin
                idx = (r == 0) ? exp_size - 1 : int'($urandom_range(0, exp_size + 3));
                ex  = (idx < exp_size) ? img[idx] : 8'h00;
                read_byte(idx, d, w, n, ra, dn);
                n_checks++;
                if (d !== ex || w != RAM_LAT + 1 || dn != (idx == exp_size - 1) ||
                    n != ((idx >= exp_hdr && idx < exp_size) ? 1 : 0)) begin
                    n_fail++; $display("FAIL rand_read[%0d] idx=%0d din=%h wait=%0d done=%b rd=%0d required %h %0d %b %0d",
                                       it, idx, d, w, dn, n, ex, RAM_LAT + 1, idx == exp_size - 1,
                                       (idx >= exp_hdr && idx < exp_size) ? 1 : 0);
                end
            end
        end
    endtask

`ifdef TAP_UPLOAD_NAME_EN
    task automatic test_name();
        logic [7:0] d; int w, n; logic [15:0] ra; bit dn;
        tape_name = {8'h41, 8'h42, 112'd0};
        build_model(16'h0501, 16'h0503, 1'b0, 1'b1, tape_name);
        do_start(16'h0501, 16'h0503, 1'b0, 1'b1);
        n_checks++;
        if (file_size !== 17'd20) begin
            n_fail++; $display("FAIL name_size file_size=%0d required 20", file_size);
        end
        for (int i = 14; i < 17; i++) begin
            read_byte(i, d, w, n, ra, dn);
            n_checks++;
            if (d !== img[i]) begin
                n_fail++; $display("FAIL name_byte[%0d] din=%h required %h", i, d, img[i]);
            end
        end
        tape_name = '0;
    endtask
`endif

    initial begin
        for (int a = 0; a < 65536; a++) mem[a] = 8'($urandom);
        test_reset();
        test_unarmed();
        test_basic_image();
        test_size_err();
        test_wrap_reset();
        test_upload_abort();
        test_back_to_back();
        test_random();
`ifdef TAP_UPLOAD_NAME_EN
        test_name();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1, "timeout");
    end

endmodule
